risc16_mem_resp: RTL and testbench

RISC16_MEM_RESP -- requirements
Module: risc16_mem_resp

---
 rtl/risc16_pkg.sv | 31 +++
 rtl/risc16_tx_fifo.sv | 59 +++++
 rtl/risc16_mem_resp.sv | 141 ++++++++++++++
 tb/tb_risc16_mem_resp.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared constants for the RISC16 memory responder.
// MMIO map, STATUS register bit positions and d_we byte-lane encodings.
package risc16_pkg;

    // MMIO window occupies the top 256 bytes of the data address space
    localparam logic [15:0] MMIO_BASE  = 16'hFF00;

    // Byte offsets inside the MMIO window (bit 0 is ignored by decode)
    localparam logic [7:0]  OFF_TXDATA = 8'h00;
    localparam logic [7:0]  OFF_STATUS = 8'h02;
    localparam logic [7:0]  OFF_CYCLE  = 8'h04;

    // STATUS register layout: {9'b0, count[3:0], ovf, empty, full}
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_CNT_W   = 4;

    // d_we lane encodings; big-endian, so bit 0 is the even (high) byte
    localparam logic [1:0]  WE_NONE = 2'b00;
    localparam logic [1:0]  WE_HI   = 2'b01;
    localparam logic [1:0]  WE_LO   = 2'b10;
    localparam logic [1:0]  WE_WORD = 2'b11;

    // True when a data address falls inside the MMIO window
    function automatic logic is_mmio(input logic [15:0] addr);
        return addr[15:8] == MMIO_BASE[15:8];
    endfunction

endpackage

// File: rtl/risc16_tx_fifo.sv
// risc16_tx_fifo: byte FIFO feeding the TX stream.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored, so a push into an empty FIFO
// becomes visible on the following cycle. Pointers wrap modulo DEPTH.
module risc16_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    r_mem [0:DEPTH-1];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    // Byte storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/risc16_mem_resp.sv
// risc16_mem_resp: dual-port RISC16 memory with optional MMIO window.
// Instruction and data reads are combinational; writes commit on clk.
// Define RISC16_MMIO_EN to enable the TX FIFO, STATUS and CYCLE registers
// at 16'hFF00..; without it every data address maps (aliased) into RAM.
module risc16_mem_resp
    import risc16_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_dout,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_din,
    output logic [15:0] d_dout,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data
);

    logic [15:0]       r_ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] w_iaddr;
    logic [ADDR_W-1:0] w_daddr;
    logic [15:0]       w_ram_rd;
    logic              w_ram_sel;
    logic              w_ram_wr_hi;
    logic              w_ram_wr_lo;
    logic              w_unused;

    assign w_iaddr  = i_addr[ADDR_W:1];
    assign w_daddr  = d_addr[ADDR_W:1];
    assign w_ram_rd = r_ram[w_daddr];
    assign i_dout   = i_oe ? r_ram[w_iaddr] : 16'h0000;

    assign w_ram_wr_hi = w_ram_sel && ((d_we & WE_HI) != WE_NONE);
    assign w_ram_wr_lo = w_ram_sel && ((d_we & WE_LO) != WE_NONE);

    // RAM byte-lane writes; reads above see the pre-write word this cycle
    always_ff @(posedge clk) begin
        if (w_ram_wr_hi) r_ram[w_daddr][15:8] <= d_din[15:8];
        if (w_ram_wr_lo) r_ram[w_daddr][7:0]  <= d_din[7:0];
    end

`ifdef RISC16_MMIO_EN
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          w_mmio;
    logic          w_sel_tx;
    logic          w_sel_st;
    logic          w_sel_cy;
    logic          w_wr_any;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [7:0]    w_push_byte;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [15:0]   w_status;
    logic          r_ovf;
    logic [15:0]   r_cycle;

    assign w_mmio    = is_mmio(d_addr);
    assign w_ram_sel = !w_mmio;
    assign w_sel_tx  = w_mmio && ({d_addr[7:1], 1'b0} == OFF_TXDATA);
    assign w_sel_st  = w_mmio && ({d_addr[7:1], 1'b0} == OFF_STATUS);
    assign w_sel_cy  = w_mmio && ({d_addr[7:1], 1'b0} == OFF_CYCLE);
    assign w_wr_any  = (d_we != WE_NONE);

    // Only a lone high-lane write sends the even byte; all else send odd
    assign w_push_byte = (d_we == WE_HI) ? d_din[15:8] : d_din[7:0];
    assign w_push      = w_sel_tx && w_wr_any;
    assign w_pop       = !w_empty && tx_ready;
    assign w_drop      = w_push && w_full && !w_pop;

    risc16_tx_fifo #(
        .DEPTH   (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_byte),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign tx_valid = !w_empty;
    assign tx_data  = w_head;

    // Sticky overflow flag, cleared by any STATUS write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_ovf <= 1'b0;
        else if (w_drop)                r_ovf <= 1'b1;
        else if (w_sel_st && w_wr_any)  r_ovf <= 1'b0;
    end

    // Free-running cycle counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cycle <= 16'h0000;
        else        r_cycle <= r_cycle + 16'h0001;
    end

    // STATUS register assembly
    always_comb begin
        w_status                          = 16'h0000;
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
        w_status[ST_OVF]                  = r_ovf;
        w_status[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(w_count);
    end

    // Data read mux: RAM below the window, registers inside it
    always_comb begin
        d_dout = 16'h0000;
        if (d_oe) begin
            if (!w_mmio)       d_dout = w_ram_rd;
            else if (w_sel_st) d_dout = w_status;
            else if (w_sel_cy) d_dout = r_cycle;
        end
    end

    assign w_unused = ^{i_addr, d_addr};
`else
    assign w_ram_sel = 1'b1;
    assign d_dout    = d_oe ? w_ram_rd : 16'h0000;
    assign tx_valid  = 1'b0;
    assign tx_data   = 8'h00;

    assign w_unused = ^{i_addr, d_addr, tx_ready, rst_n};
`endif

endmodule

// File: tb/tb_risc16_mem_resp.sv
// tb_risc16_mem_resp: randomized bench with a behavioural reference model
// (word array + byte queue) and a per-cycle compare process, plus literal
// directed checks. Honors RISC16_MMIO_EN the same way the design does.
module tb_risc16_mem_resp;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] i_addr = '0;
    logic        i_oe = 1'b0;
    logic [15:0] i_dout;
    logic [15:0] d_addr = '0;
    logic        d_oe = 1'b0;
    logic [1:0]  d_we = '0;
    logic [15:0] d_din = '0;
    logic [15:0] d_dout;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    risc16_mem_resp #(.ADDR_W(12), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_oe(i_oe), .i_dout(i_dout),
        .d_addr(d_addr), .d_oe(d_oe), .d_we(d_we), .d_din(d_din), .d_dout(d_dout),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [15:0]  m_ram [4096];
    bit [1:0]   m_bv  [4096];
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit [15:0]  m_cyc = '0;

    function automatic bit m_is_mmio(input logic [15:0] a);
`ifdef RISC16_MMIO_EN
        return a >= 16'hFF00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] m_status();
        int n;
        n = q.size();
        return {9'b0, 4'(n), m_ovf, (n == 0), (n == DEPTH)};
    endfunction

    function automatic logic [15:0] m_dread(input logic [15:0] a);
        if (m_is_mmio(a)) begin
            case (a & 16'hFFFE)
                16'hFF02: return m_status();
                16'hFF04: return m_cyc;
                default:  return 16'h0000;
            endcase
        end
        return m_ram[int'(a[12:1])];
    endfunction

    function automatic bit m_dvalid(input logic [15:0] a);
        return m_is_mmio(a) || (m_bv[int'(a[12:1])] == 2'b11);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_cyc = '0;
        end else begin
            bit pop, push;
            logic [7:0] b;
            int w;
            pop  = (q.size() != 0) && tx_ready;
            push = 1'b0;
            b    = '0;
            if (d_we != 2'b00) begin
                if (m_is_mmio(d_addr)) begin
                    if ((d_addr & 16'hFFFE) == 16'hFF00) begin
                        push = 1'b1;
                        b = (d_we == 2'b01) ? d_din[15:8] : d_din[7:0];
                    end
                    if ((d_addr & 16'hFFFE) == 16'hFF02) m_ovf = 1'b0;
                end else begin
                    w = int'(d_addr[12:1]);
                    if (d_we[0]) m_ram[w][15:8] = d_din[15:8];
                    if (d_we[1]) m_ram[w][7:0]  = d_din[7:0];
                    m_bv[w] = m_bv[w] | d_we;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(b);
                else m_ovf = 1'b1;
            end
            m_cyc = m_cyc + 16'd1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            if (!i_oe) chk("i_dout_off", i_dout, 16'h0000);
            else if (m_bv[int'(i_addr[12:1])] == 2'b11) chk("i_dout", i_dout, m_ram[int'(i_addr[12:1])]);
            if (!d_oe) chk("d_dout_off", d_dout, 16'h0000);
            else if (m_dvalid(d_addr)) chk("d_dout", d_dout, m_dread(d_addr));
`ifdef RISC16_MMIO_EN
            chk("tx_valid", tx_valid, q.size() != 0);
            if (q.size() != 0) chk("tx_data", tx_data, q[0]);
`else
            chk("tx_valid", tx_valid, 1'b0);
            chk("tx_data", tx_data, 8'h00);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic [15:0] ia, input logic io, input logic [15:0] da,
                       input logic doe, input logic [1:0] we, input logic [15:0] din,
                       input logic rdy);
        i_addr = ia; i_oe = io; d_addr = da; d_oe = doe; d_we = we; d_din = din; tx_ready = rdy;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_ram_addr();
        logic [15:0] a;
        a = 16'(($urandom_range(0, 6) << 13) | ($urandom_range(0, 63) << 1) | $urandom_range(0, 1));
        return a;
    endfunction

    initial begin
        logic [15:0] v10, v15;
        #1 rst_n = 1'b0;
        #2 chk_on = 1'b1;
        // combinational reads during reset
        drv(16'h0, 1'b0, 16'hFF02, 1'b1, 2'b00, 16'h0, 1'b0);
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
`ifdef RISC16_MMIO_EN
        chk("rst_status", d_dout, 16'h0002);
`endif
        drv(16'h0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // fill a 64-word window so random reads always hit known data
        for (int w = 0; w < 64; w++) begin
            drv(16'h0, 1'b0, 16'(w << 1), 1'b0, 2'b11, 16'($urandom), 1'b0);
            nxt();
        end

        // word write, then read on both ports
        drv(16'h0, 1'b0, 16'h0010, 1'b0, 2'b11, 16'hA1B2, 1'b0); nxt();
        drv(16'h0011, 1'b1, 16'h0010, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk);
        chk("word_d", d_dout, 16'hA1B2);
        chk("word_i", i_dout, 16'hA1B2);
        nxt();
        // big-endian byte lanes
        drv(16'h0, 1'b0, 16'h0010, 1'b0, 2'b01, 16'h5500, 1'b0); nxt();
        drv(16'h0, 1'b0, 16'h0010, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("byte_hi", d_dout, 16'h55B2); nxt();
        drv(16'h0, 1'b0, 16'h0010, 1'b0, 2'b10, 16'h0066, 1'b0); nxt();
        drv(16'h0, 1'b0, 16'h0010, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("byte_lo", d_dout, 16'h5566); nxt();
        // same-cycle read+write returns pre-write data
        drv(16'h0010, 1'b1, 16'h0010, 1'b1, 2'b11, 16'h1111, 1'b0);
        @(negedge clk);
        chk("rw_d_old", d_dout, 16'h5566);
        chk("rw_i_old", i_dout, 16'h5566);
        nxt();
        drv(16'h0, 1'b0, 16'h0010, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("rw_new", d_dout, 16'h1111); nxt();

`ifdef RISC16_MMIO_EN
        // overflow: five pushes into a 4-deep FIFO with no consumer
        for (int k = 1; k <= 5; k++) begin
            drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b11, 16'(k), 1'b0);
            @(negedge clk);
            if (k >= 2) chk("tx_hold", tx_data, 8'h01);
            nxt();
        end
        drv(16'h0, 1'b0, 16'hFF02, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("status_ovf_full", d_dout, 16'h0025); nxt();
        drv(16'h0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("drain_valid", tx_valid, 1'b1);
            chk("drain_data", tx_data, 8'(k));
            nxt();
        end
        @(negedge clk); chk("drain_empty", tx_valid, 1'b0); nxt();
        drv(16'h0, 1'b0, 16'hFF02, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("status_ovf_empty", d_dout, 16'h0006); nxt();
        drv(16'h0, 1'b0, 16'hFF02, 1'b0, 2'b11, 16'h0, 1'b0); nxt();
        drv(16'h0, 1'b0, 16'hFF02, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("status_cleared", d_dout, 16'h0002); nxt();
        // push into empty FIFO with ready high: visible next cycle
        drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b11, 16'h0077, 1'b1);
        @(negedge clk); chk("empty_push_now", tx_valid, 1'b0); nxt();
        drv(16'h0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b1);
        @(negedge clk);
        chk("empty_push_next", tx_valid, 1'b1);
        chk("empty_push_data", tx_data, 8'h77);
        nxt();
        // full FIFO: push while popping is accepted
        for (int k = 0; k < 4; k++) begin
            drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b11, 16'(8'h11 + k), 1'b0); nxt();
        end
        drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b11, 16'h0009, 1'b1);
        @(negedge clk); chk("full_head", tx_data, 8'h11); nxt();
        drv(16'h0, 1'b0, 16'hFF02, 1'b1, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("full_pushpop_status", d_dout, 16'h0021); nxt();
        drv(16'h0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_drain", tx_data, (k == 3) ? 8'h09 : 8'(8'h12 + k));
            nxt();
        end
        // high-lane-only push sends the even byte
        drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b01, 16'hC3A5, 1'b0); nxt();
        drv(16'h0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        @(negedge clk); chk("push_hi_byte", tx_data, 8'hC3); nxt();
`else
        // without MMIO the top page is plain aliased RAM
        drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b11, 16'h1234, 1'b1); nxt();
        drv(16'h0, 1'b0, 16'hFF00, 1'b1, 2'b00, 16'h0, 1'b1);
        @(negedge clk);
        chk("alias_ff00", d_dout, 16'h1234);
        chk("alias_txv", tx_valid, 1'b0);
        nxt();
        drv(16'h1F00, 1'b1, 16'h1F00, 1'b1, 2'b00, 16'h0, 1'b1);
        @(negedge clk);
        chk("alias_1f00_d", d_dout, 16'h1234);
        chk("alias_1f00_i", i_dout, 16'h1234);
        nxt();
`endif

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] da;
            logic [1:0]  we;
            int bias;
            bias = ((i / 250) % 2) ? 20 : 75;
            da = rnd_ram_addr();
`ifdef RISC16_MMIO_EN
            if ($urandom_range(0, 9) >= 6) da = 16'(16'hFF00 + 2 * $urandom_range(0, 3));
`endif
            we = $urandom_range(0, 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            drv(rnd_ram_addr(), 1'($urandom_range(0, 1)), da, 1'($urandom_range(0, 1)),
                we, 16'($urandom), 1'($urandom_range(0, 99) < bias));
            nxt();
        end

        // reset mid-transfer, then cycle counter restart
        for (int k = 0; k < 3; k++) begin
            drv(16'h0, 1'b0, 16'hFF00, 1'b0, 2'b11, 16'(8'hE0 + k), 1'b0); nxt();
        end
        drv(16'h0, 1'b0, 16'hFF04, 1'b1, 2'b00, 16'h0, 1'b0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("midrst_valid", tx_valid, 1'b0);
`ifdef RISC16_MMIO_EN
        chk("midrst_cycle", d_dout, 16'h0000);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
`ifdef RISC16_MMIO_EN
        #1 chk("cycle_restart", d_dout, 16'h0000);
        repeat (10) @(posedge clk);
        #1 v10 = d_dout;
        repeat (5) @(posedge clk);
        #1 v15 = d_dout;
        chk("cycle_at10", v10, 16'd10);
        chk("cycle_delta", v15 - v10, 16'd5);
`else
        repeat (3) nxt();
`endif
        drv(16'h0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b0);
        nxt();
        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
